// File: rtl/segment_fader_chaser_if.sv
// Control and display bundle for segment_fader_chaser: run-time controls in,
// registered LED pins, path position and step strobe out.
interface segment_fader_chaser_if #(
    parameter int CHANNELS = 8,
    parameter int PATH_LEN = 8
);
    localparam int PW = (PATH_LEN > 1) ? $clog2(PATH_LEN) : 1;

    logic                enable;
    logic [2:0]          speed;
    logic                direction;
    logic [1:0]          mode;
    logic                decay_mode;
    logic [CHANNELS-1:0] led_out;
    logic [PW-1:0]       pos;
    logic                step_pulse;

    modport master (
        output enable, speed, direction, mode, decay_mode,
        input  led_out, pos, step_pulse
    );

    modport slave (
        input  enable, speed, direction, mode, decay_mode,
        output led_out, pos, step_pulse
    );
endinterface

// File: rtl/segment_fader_chaser.sv
// Head-and-fading-tail chaser over a programmable LED path, one brightness
// lane per channel rendered through a shared free-running PWM counter.
module segment_fader_lane #(
    parameter int BRIGHT_WIDTH = 5,
    parameter bit COMMON_ANODE = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    clear,
    input  logic                    decay,
    input  logic                    decay_mode,
    input  logic                    force_max,
    input  logic [BRIGHT_WIDTH-1:0] pwm,
    output logic                    led_out
);
    logic [BRIGHT_WIDTH-1:0] bright_q, bright_d;
    logic                    led_q, led_d;

    always_comb begin
        bright_d = bright_q;
        if (clear) begin
            bright_d = '0;
        end else begin
            if (decay) begin
                if (decay_mode) bright_d = (bright_q == '0) ? '0 : bright_q - 1'b1;
                else            bright_d = bright_q >> 1;
            end
            // the head wins over decay when both land on the same edge
            if (force_max) bright_d = '1;
        end
        led_d = (bright_q > pwm) ^ COMMON_ANODE;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bright_q <= '0;
            led_q    <= COMMON_ANODE;
        end else begin
            bright_q <= bright_d;
            led_q    <= led_d;
        end
    end

    assign led_out = led_q;
endmodule

module segment_fader_chaser #(
    parameter int  CHANNELS           = 8,
    parameter int  PATH_LEN           = 8,
    localparam int IW                 = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int PW                 = (PATH_LEN > 1) ? $clog2(PATH_LEN) : 1,
    parameter logic [IW*PATH_LEN-1:0] PATH = 24'hB93988,
    parameter int  STEP_COUNTER_WIDTH = 22,
    parameter int  BRIGHT_WIDTH       = 5,
    parameter bit  COMMON_ANODE       = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    segment_fader_chaser_if.slave bus
);
    typedef enum logic [1:0] {
        MODE_LOOP   = 2'b00,
        MODE_BOUNCE = 2'b01,
        MODE_HOLD   = 2'b10,
        MODE_BLANK  = 2'b11
    } mode_e;

    localparam int            SCW  = STEP_COUNTER_WIDTH;
    localparam logic [PW-1:0] LAST = PW'(PATH_LEN - 1);

    logic [SCW-1:0]          counter_q, counter_d;
    logic [PW-1:0]           pos_q, pos_d;
    logic                    bdir_q, bdir_d;
    logic [BRIGHT_WIDTH-1:0] pwm_q, pwm_d;
    logic                    step_pulse_q, step_pulse_d;

    logic [SCW-1:0]      period;
    logic                step;
    mode_e               mode_s;
    logic                head_on;
    logic [IW-1:0]       head_ch;
    logic [IW-1:0]       path_tbl [PATH_LEN];
    logic [CHANNELS-1:0] force_vec;
    logic [CHANNELS-1:0] led_vec;

    for (genvar p = 0; p < PATH_LEN; p++) begin : g_path
        assign path_tbl[p] = PATH[IW*p +: IW];
    end

    assign mode_s = mode_e'(bus.mode);
    assign period = {bus.speed, {(SCW-3){1'b1}}};

    always_comb begin
        // >= rather than == so that lowering speed mid-count steps at once
        step         = bus.enable && (counter_q >= period);
        step_pulse_d = step;
        counter_d    = counter_q;
        if (bus.enable) counter_d = step ? '0 : counter_q + 1'b1;

        pos_d  = pos_q;
        bdir_d = bdir_q;
        if (step) begin
            unique case (mode_s)
                MODE_LOOP: begin
                    if (bus.direction) pos_d = (pos_q == LAST) ? '0 : pos_q + 1'b1;
                    else               pos_d = (pos_q == '0) ? LAST : pos_q - 1'b1;
                end
                MODE_BOUNCE: begin
                    if (PATH_LEN > 1) begin
                        if (bdir_q) begin
                            if (pos_q == LAST) begin
                                bdir_d = 1'b0;
                                pos_d  = LAST - 1'b1;
                            end else begin
                                pos_d = pos_q + 1'b1;
                            end
                        end else begin
                            if (pos_q == '0) begin
                                bdir_d = 1'b1;
                                pos_d  = PW'(1);
                            end else begin
                                pos_d = pos_q - 1'b1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end

        pwm_d   = pwm_q + 1'b1;
        head_on = (mode_s != MODE_BLANK);
        head_ch = path_tbl[pos_d];
        for (int i = 0; i < CHANNELS; i++) begin
            force_vec[i] = head_on && (head_ch == IW'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            counter_q    <= '0;
            pos_q        <= '0;
            bdir_q       <= 1'b1;
            pwm_q        <= '0;
            step_pulse_q <= 1'b0;
        end else begin
            counter_q    <= counter_d;
            pos_q        <= pos_d;
            bdir_q       <= bdir_d;
            pwm_q        <= pwm_d;
            step_pulse_q <= step_pulse_d;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        segment_fader_lane #(
            .BRIGHT_WIDTH (BRIGHT_WIDTH),
            .COMMON_ANODE (COMMON_ANODE)
        ) u_lane (
            .clk        (clk),
            .reset_n    (reset_n),
            .clear      (mode_s == MODE_BLANK),
            .decay      (step),
            .decay_mode (bus.decay_mode),
            .force_max  (force_vec[i]),
            .pwm        (pwm_q),
            .led_out    (led_vec[i])
        );
    end

    assign bus.led_out    = led_vec;
    assign bus.pos        = pos_q;
    assign bus.step_pulse = step_pulse_q;
endmodule

// File: doc/segment_fader_chaser.md
# segment_fader_chaser

Parametrised successor to the single-pattern segment chaser. It moves a lit "head" along a programmable path of LED channels (default: a figure-8 over a 7-segment display plus DP) and leaves a fading tail behind it. Each channel's brightness is rendered by a shared free-running PWM. Speed, direction, path mode (loop, bounce, hold, blank) and decay law (exponential or linear) are selectable at run time. The block drives the display pins directly at the top level of the user design.

## Interface
Parameters:
- `CHANNELS`, 8: number of LED outputs; index width is `IW = $clog2(CHANNELS)`.
- `PATH_LEN`, 8: number of path positions; position width is `PW = $clog2(PATH_LEN)`, minimum 1.
- `PATH`, 24'hB93988: flattened channel table, entry i at `[IW*i +: IW]`. The default gives channels 0,1,6,4,3,2,6,5.
- `STEP_COUNTER_WIDTH`, 22: width of the step timer; must be ≥ 4.
- `BRIGHT_WIDTH`, 5: brightness width and PWM counter width.
- `COMMON_ANODE`, 1: when 1, `led_out` is inverted (0 = lit).

Ports:
- `clk` in 1: sole clock, rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `enable` in 1: when 1, the step timer runs.
- `speed` in 3: step period select.
- `direction` in 1: loop mode only; 1 = forward (pos+1), 0 = reverse.
- `mode` in 2: 00 loop, 01 bounce, 10 hold, 11 blank.
- `decay_mode` in 1: 0 = shift right by 1, 1 = subtract 1 saturating at 0.
- `led_out` out CHANNELS: registered PWM outputs.
- `pos` out PW: current path position.
- `step_pulse` out 1: one-cycle strobe on each step.

## Operation
- **Step timer.** `period = {speed, {(STEP_COUNTER_WIDTH-3){1'b1}}}`.
  - If `enable` and `counter >= period`: `counter` ← 0 and a step occurs.
  - Otherwise, if `enable`: `counter` increments.
  - If `!enable`: `counter` holds.
  - Because the compare is `>=`, lowering `speed` mid-count causes an immediate step.
- **Step action, by mode:**
  - Loop: pos ±1 per `direction`, wrapping 7→0 and 0→7 (modulo PATH_LEN).
  - Bounce: an internal `bdir` register drives motion and `direction` is ignored. At pos = PATH_LEN-1 while going up, `bdir` flips and pos becomes PATH_LEN-2; symmetric at 0. With PATH_LEN=1, pos stays 0.
  - Hold: pos frozen; decay still applies.
  - Blank: pos frozen; all brightness values forced to 0 every cycle; no head forcing.
- **Decay.** On every step in modes 00/01/10, every channel decays per `decay_mode`.
- **Head forcing.** Every cycle in modes 00/01/10, `bright[PATH[pos]]` ← all ones, using the updated pos on a step cycle. Forcing overrides decay on the same cycle. Duplicate path entries are legal.
- **Mode changes.** Switching from bounce to loop uses `direction` from the next step. Switching into bounce keeps the current `bdir`.
- **PWM.** `pwm` is a free-running BRIGHT_WIDTH counter that wraps. The lit condition is `bright[i] > pwm`, so duty = `bright/2^BRIGHT_WIDTH`, and full brightness is on 31 of 32 cycles. `led_out[i]` = lit XOR COMMON_ANODE, registered.
- **Reset (reset_n=0 at a clk edge):**
  - `counter`, `pos`, `pwm`, and all `bright` values are 0; `bdir` is up.
  - `step_pulse` is 0.
  - `led_out` is all off: 8'hFF when COMMON_ANODE, else 8'h00.
  - Reset overrides all other inputs.
  - Reset mid-step discards the step.

## Timing
- Step period is `period+1` clocks. With STEP_COUNTER_WIDTH=6 and speed=0, a step occurs every 8 clocks; with speed=7, every 64.
- `step_pulse` and the new `pos` appear in the cycle after the edge that performs the step.
- Brightness updates on the same edge as the step. `led_out` reflects `bright` and `pwm` with 1 cycle of latency.
- After reset release, the first edge sets `bright[PATH[0]]` = max, and `led_out` can show the head one edge later.
- `speed`, `direction`, `mode`, `decay_mode` and `enable` are used unregistered and must be synchronous to `clk`.
- Blank takes effect on the next edge, and `led_out` goes dark by the second edge.

## Test plan
Bench parameters: STEP_COUNTER_WIDTH=6, defaults elsewhere.
- **Reset.** Hold reset_n=0 for 3 clocks with random inputs → `led_out`=8'hFF, `pos`=0, `step_pulse`=0. Release → ch0 duty measures 31/32 over 64 clocks.
- **Loop forward.** mode=00, direction=1, speed=0 → `step_pulse` every 8 clocks; `pos` 0,1,…,7,0; head channels 0,1,6,4,3,2,6,5.
- **Reverse and speed.** direction=0 at pos 0 → next `pos`=7 (ch5). Set speed=7 → 64-clock spacing. Drop speed 7→0 while counter=20 → immediate step.
- **Bounce.** mode=01 → `pos` 0..7,6,5,…,0,1; toggling `direction` has no effect.
- **Decay.** Exponential: ch1 duty after the head leaves, per step, is 31,15,7,3,1,0 (out of 32). Linear: 31,30,29,…. Duplicate ch6 is re-forced to 31 on its second visit.
- **Hold, blank, enable.** mode=10 → pos frozen while the tail fades. mode=11 → `led_out`=8'hFF within 2 clocks. enable=0 for 200 clocks → no `step_pulse`, pos unchanged, PWM still running.
